// File: rtl/mem_write_checker.sv
// Self-checker for dmem write traffic: matches snooped writes against a latched table
// of expected (address, data) pairs and reports pass / fail / timeout with diagnostics.
module mem_write_checker #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int NUM_CHECKS = 4,
   parameter int TIMEOUT_W  = 16,
   parameter int ORDERED    = 1,
   localparam int CNT_W     = $clog2(NUM_CHECKS + 1),
   localparam int IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           memwrite,
   input  logic [ADDR_W-1:0]              dataadr,
   input  logic [DATA_W-1:0]              writedata,
   input  logic [NUM_CHECKS*ADDR_W-1:0]   exp_addr,
   input  logic [NUM_CHECKS*DATA_W-1:0]   exp_data,
   input  logic [TIMEOUT_W-1:0]           timeout_cycles,
   output logic                           done,
   output logic                           pass,
   output logic                           fail,
   output logic                           timeout,
   output logic [CNT_W-1:0]               match_count,
   output logic [IDX_W-1:0]               fail_idx,
   output logic [DATA_W-1:0]              fail_data,
   output logic [TIMEOUT_W-1:0]           cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_PASS,
      S_FAIL,
      S_TIMEOUT
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      ea_q [NUM_CHECKS];
   logic [ADDR_W-1:0]      ea_d [NUM_CHECKS];
   logic [DATA_W-1:0]      ed_q [NUM_CHECKS];
   logic [DATA_W-1:0]      ed_d [NUM_CHECKS];
   logic [TIMEOUT_W-1:0]   limit_q, limit_d;
   logic [NUM_CHECKS-1:0]  matched_q, matched_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [IDX_W-1:0]       fidx_q, fidx_d;
   logic [DATA_W-1:0]      fdata_q, fdata_d;
   logic [TIMEOUT_W-1:0]   cycle_q, cycle_d;
   logic                   pass_q, pass_d;
   logic                   fail_q, fail_d;
   logic                   tmo_q, tmo_d;
   logic                   done_q, done_d;

   logic                   hit_found;
   logic                   am_found;
   logic [IDX_W-1:0]       hit_idx;
   logic [IDX_W-1:0]       am_idx;
   logic [IDX_W-1:0]       k_idx;
   logic                   mismatch;
   logic                   matched_now;

   always_comb begin
      state_d     = state_q;
      ea_d        = ea_q;
      ed_d        = ed_q;
      limit_d     = limit_q;
      matched_d   = matched_q;
      count_d     = count_q;
      fidx_d      = fidx_q;
      fdata_d     = fdata_q;
      cycle_d     = cycle_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      tmo_d       = tmo_q;
      done_d      = done_q;
      hit_found   = 1'b0;
      am_found    = 1'b0;
      hit_idx     = '0;
      am_idx      = '0;
      k_idx       = IDX_W'(count_q);
      mismatch    = 1'b0;
      matched_now = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (enable) begin
               for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
                  ea_d[i] = exp_addr[i*ADDR_W +: ADDR_W];
                  ed_d[i] = exp_data[i*DATA_W +: DATA_W];
               end
               limit_d   = timeout_cycles;
               matched_d = '0;
               count_d   = '0;
               fidx_d    = '0;
               fdata_d   = '0;
               cycle_d   = '0;
               state_d   = S_RUN;
            end
         end

         S_RUN: begin
            if (cycle_q != '1) cycle_d = cycle_q + TIMEOUT_W'(1);

            if (memwrite) begin
               if (ORDERED != 0) begin
                  if (dataadr == ea_q[k_idx]) begin
                     if (writedata == ed_q[k_idx]) begin
                        matched_now = 1'b1;
                     end else begin
                        mismatch = 1'b1;
                        am_idx   = k_idx;
                     end
                  end
               end else begin
                  // Lowest unmatched entry with full match wins; a mismatch is reported
                  // only when no unmatched entry at this address accepts the data.
                  for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
                     if (!matched_q[i] && dataadr == ea_q[i]) begin
                        if (!am_found) begin
                           am_found = 1'b1;
                           am_idx   = IDX_W'(i);
                        end
                        if (!hit_found && writedata == ed_q[i]) begin
                           hit_found = 1'b1;
                           hit_idx   = IDX_W'(i);
                        end
                     end
                  end
                  if (hit_found) begin
                     matched_now        = 1'b1;
                     matched_d[hit_idx] = 1'b1;
                  end else if (am_found) begin
                     mismatch = 1'b1;
                  end
               end
            end

            if (matched_now) count_d = count_q + CNT_W'(1);

            // Precedence on a shared edge: fail, then pass, then timeout.
            if (mismatch) begin
               fidx_d  = am_idx;
               fdata_d = writedata;
               fail_d  = 1'b1;
               done_d  = 1'b1;
               state_d = S_FAIL;
            end else if (count_d == CNT_W'(NUM_CHECKS)) begin
               pass_d  = 1'b1;
               done_d  = 1'b1;
               state_d = S_PASS;
            end else if (limit_q != '0 && cycle_q == limit_q - TIMEOUT_W'(1)) begin
               tmo_d   = 1'b1;
               done_d  = 1'b1;
               state_d = S_TIMEOUT;
            end
         end

         S_PASS, S_FAIL, S_TIMEOUT: begin
         end

         default: state_d = S_IDLE;
      endcase

      if (!enable) begin
         state_d   = S_IDLE;
         matched_d = '0;
         count_d   = '0;
         fidx_d    = '0;
         fdata_d   = '0;
         cycle_d   = '0;
         pass_d    = 1'b0;
         fail_d    = 1'b0;
         tmo_d     = 1'b0;
         done_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         ea_q      <= '{default: '0};
         ed_q      <= '{default: '0};
         limit_q   <= '0;
         matched_q <= '0;
         count_q   <= '0;
         fidx_q    <= '0;
         fdata_q   <= '0;
         cycle_q   <= '0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         tmo_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ea_q      <= ea_d;
         ed_q      <= ed_d;
         limit_q   <= limit_d;
         matched_q <= matched_d;
         count_q   <= count_d;
         fidx_q    <= fidx_d;
         fdata_q   <= fdata_d;
         cycle_q   <= cycle_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         tmo_q     <= tmo_d;
         done_q    <= done_d;
      end
   end

   assign done        = done_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign timeout     = tmo_q;
   assign match_count = count_q;
   assign fail_idx    = fidx_q;
   assign fail_data   = fdata_q;
   assign cycle_count = cycle_q;

endmodule
